// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the EX stage and DataMem.
// Decodes MIPS lb/lh/lw/lbu/lhu/sb/sh/sw. It issues one word-aligned DataMem
// access at a time and uses read-modify-write for sub-word stores. Results go
// back as a single-cycle resp pulse.
// Build option: define MEM_MISALIGN_TRAP_EN to fault misaligned accesses.
// Without it, the low address bits are forced to natural alignment and the
// access goes ahead.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Access size codes
    localparam logic [1:0] SZ_B    = 2'd0;
    localparam logic [1:0] SZ_H    = 2'd1;
    localparam logic [1:0] SZ_W    = 2'd2;
    localparam logic [1:0] SZ_NONE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LD,
        S_MRG,
        S_WR,
        S_RESP
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_B;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            OP_LW, OP_SW:         return SZ_W;
            default:              return SZ_NONE;
        endcase
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] lo);
        case (op_size(op))
            SZ_H:    return lo[0];
            SZ_W:    return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] align_addr(input logic [5:0] op,
                                                     input logic [ADDR_W-1:0] a);
        case (op_size(op))
            SZ_H:    return {a[ADDR_W-1:1], 1'b0};
            SZ_W:    return {a[ADDR_W-1:2], 2'b00};
            default: return a;
        endcase
    endfunction

    // Pick the addressed lane out of the word and sign/zero extend it.
    function automatic logic [31:0] load_extract(input logic [5:0]  op,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [31:0]        shifted;
        logic [7:0]         b;
        logic [15:0]        h;
        logic signed [31:0] sx;
        shifted = word >> {lane, 3'b000};
        b       = shifted[7:0];
        h       = lane[1] ? word[31:16] : word[15:0];
        sx      = '0;
        case (op)
            OP_LB:   sx = 32'($signed(b));
            OP_LH:   sx = 32'($signed(h));
            OP_LBU:  sx = {24'h0, b};
            OP_LHU:  sx = {16'h0, h};
            OP_LW:   sx = word;
            default: sx = '0;
        endcase
        return sx;
    endfunction

    // Replace the addressed lane(s) of the old word with the store data.
    function automatic logic [31:0] store_merge(input logic [5:0]  op,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word,
                                                input logic [31:0] wd);
        logic [31:0] m;
        logic [31:0] d;
        case (op_size(op))
            SZ_B: begin
                m = 32'h0000_00FF << {lane, 3'b000};
                d = {4{wd[7:0]}};
            end
            SZ_H: begin
                m = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                d = {2{wd[15:0]}};
            end
            default: begin
                m = 32'hFFFF_FFFF;
                d = wd;
            end
        endcase
        return (word & ~m) | (d & m);
    endfunction

    state_t              state_q;
    state_t              state_d;
    logic                accept;
    logic                mis_now;
    logic                mis_q;
    logic [ADDR_W-1:0]   eff_addr;
    logic [5:0]          op_p0;
    logic [ADDR_W-1:0]   addr_p0;
    logic [31:0]         wdata_p0;
    logic [31:0]         data_p1;

    assign accept = (state_q == S_IDLE) && req_valid;

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_now  = (is_load(opcode) || is_store(opcode)) && misaligned(opcode, addr[1:0]);
    assign eff_addr = addr;
`else
    assign mis_now  = 1'b0;
    assign eff_addr = align_addr(opcode, addr);
`endif

    // State register; reset abandons any operation in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fault flag for the accepted request, reported in RESP
    always_ff @(posedge CLK) begin
        if (RST) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= mis_now;
        end
    end

    // Request capture (p0) and load result / merged store word (p1)
    always_ff @(posedge CLK) begin
        if (accept) begin
            op_p0    <= opcode;
            addr_p0  <= eff_addr;
            wdata_p0 <= wdata;
        end
        if (state_q == S_LD) begin
            data_p1 <= load_extract(op_p0, addr_p0[1:0], mem_rdata);
        end else if (state_q == S_MRG) begin
            data_p1 <= store_merge(op_p0, addr_p0[1:0], mem_rdata, wdata_p0);
        end else if (accept) begin
            data_p1 <= wdata;
        end
    end

    // Next-state sequencing and DataMem / response outputs
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        rdata      = '0;
        misalign   = 1'b0;
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (mis_now || !(is_load(opcode) || is_store(opcode))) begin
                        state_d = S_RESP;
                    end else if (opcode == OP_SW) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                mem_re   = 1'b1;
                mem_addr = {addr_p0[ADDR_W-1:2], 2'b00};
                state_d  = is_load(op_p0) ? S_LD : S_MRG;
            end
            S_LD: begin
                state_d = S_RESP;
            end
            S_MRG: begin
                state_d = S_WR;
            end
            S_WR: begin
                mem_we    = ~RST;
                mem_addr  = {addr_p0[ADDR_W-1:2], 2'b00};
                mem_wdata = data_p1;
                state_d   = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                misalign   = mis_q;
                if (is_load(op_p0) && !mis_q) begin
                    rdata = data_p1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a small word memory answers the
// DUT's DataMem port, and a behavioural model predicts each operation's result.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  opcode = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        misalign;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] dmem    [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  lat;
        logic [1:0]  nre;
        logic [3:0]  rcyc;
        logic [1:0]  nwe;
        logic [3:0]  wcyc;
        logic [31:0] wdat;
        logic [31:0] maddr;
        logic        leak;
        logic        stuck;
    } res_t;

    mem_access_unit #(.ADDR_W(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .opcode     (opcode),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .misalign   (misalign),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (pl_en) dmem[pl_idx] <= pl_val;
        else if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
        if (mem_re) mem_rdata <= dmem[mem_addr[7:2]];
    end

    // Reference: result of one request computed straight from the ISA rules.
    function automatic res_t model(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] wd);
        res_t        r;
        int          sz;
        bit          ld, st, sgn;
        logic [31:0] ea, w, v, m;
        int          sh;
        r = '0; ld = 0; st = 0; sgn = 0; sz = 1; ea = a;
        case (op)
            6'h20: begin ld = 1; sz = 1; sgn = 1; end
            6'h21: begin ld = 1; sz = 2; sgn = 1; end
            6'h23: begin ld = 1; sz = 4; end
            6'h24: begin ld = 1; sz = 1; end
            6'h25: begin ld = 1; sz = 2; end
            6'h28: begin st = 1; sz = 1; end
            6'h29: begin st = 1; sz = 2; end
            6'h2B: begin st = 1; sz = 4; end
            default: ;
        endcase
        r.lat = 4'd1;
        if (!ld && !st) return r;
        if ((ea % sz) != 0) begin
`ifdef MEM_MISALIGN_TRAP_EN
            r.mis = 1'b1;
            return r;
`else
            ea = ea - (ea % sz);
`endif
        end
        w = ref_mem[ea[7:2]];
        sh = 8 * (ea % 4);
        r.maddr = ea & 32'hFFFF_FFFC;
        if (ld) begin
            v = w >> sh;
            if (sz == 1) v = sgn ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
            else if (sz == 2) v = sgn ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
            r.rdata = v; r.lat = 4'd3; r.nre = 2'd1; r.rcyc = 4'd1;
        end else begin
            m = (sz == 4) ? 32'hFFFF_FFFF : (sz == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
            v = (w & ~(m << sh)) | ((wd & m) << sh);
            ref_mem[ea[7:2]] = v;
            r.wdat = v; r.nwe = 2'd1;
            if (sz == 4) begin
                r.lat = 4'd2; r.wcyc = 4'd1;
            end else begin
                r.lat = 4'd4; r.nre = 2'd1; r.rcyc = 4'd1; r.wcyc = 4'd3;
            end
        end
        return r;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("rd=%h mis=%b lat=%0d re=%0d@%0d we=%0d@%0d wd=%h ma=%h leak=%b stuck=%b",
                         r.rdata, r.mis, r.lat, r.nre, r.rcyc, r.nwe, r.wcyc, r.wdat,
                         r.maddr, r.leak, r.stuck);
    endfunction

    task automatic preload(input logic [5:0] i, input logic [31:0] v);
        @(negedge CLK);
        pl_en = 1'b1; pl_idx = i; pl_val = v; ref_mem[i] = v;
        @(negedge CLK);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
        int n;
        @(negedge CLK);
        req_valid = 1'b1; opcode = op; addr = a; wdata = wd; n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK);
        #1;
        req_valid = 1'b0; opcode = 6'($urandom); addr = $urandom; wdata = $urandom;
    endtask

    task automatic observe(output res_t r);
        int c;
        bit done;
        r = '0; done = 0; c = 0;
        while (!done && c < 12) begin
            @(negedge CLK);
            c++;
            if (mem_re === 1'b1) begin r.nre = r.nre + 2'd1; r.rcyc = c[3:0]; r.maddr = mem_addr; end
            if (mem_we === 1'b1) begin r.nwe = r.nwe + 2'd1; r.wcyc = c[3:0]; r.wdat = mem_wdata; r.maddr = mem_addr; end
            if (mem_re === 1'b1 && mem_we === 1'b1) r.leak = 1'b1;
            if (mem_re !== 1'b1 && mem_we !== 1'b1 && (mem_addr !== 32'h0 || mem_wdata !== 32'h0)) r.leak = 1'b1;
            if (resp_valid === 1'b1) begin
                r.rdata = rdata; r.mis = misalign; r.lat = c[3:0]; done = 1;
            end else if (rdata !== 32'h0 || misalign !== 1'b0) begin
                r.leak = 1'b1;
            end
        end
        if (!done) r.lat = 4'hF;
        else begin
            @(negedge CLK);
            if (resp_valid !== 1'b0) r.stuck = 1'b1;
        end
    endtask

    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                          output res_t obs);
        issue(op, a, wd);
        observe(obs);
    endtask

    task automatic test_reset();
        RST = 1'b1; req_valid = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h want=0", rdata); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b want=0", misalign); end
        n_checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ctl got re=%b we=%b want 0 0", mem_re, mem_we); end
        n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus got addr=%h wd=%h want 0 0", mem_addr, mem_wdata); end
    endtask

    task automatic test_load_word();
        res_t obs, exp;
        preload(6'd4, 32'hDEAD_BEEF);
        run_op(6'h23, 32'h10, 32'h0, obs);
        exp = model(6'h23, 32'h10, 32'h0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL lw_0x10 got %s want %s", fmt(obs), fmt(exp)); end
        n_checks++; if (obs.rdata !== 32'hDEAD_BEEF || obs.lat !== 4'd3 || obs.rcyc !== 4'd1)
            begin n_fail++; $display("FAIL lw_0x10_const got rd=%h lat=%0d rcyc=%0d want DEADBEEF 3 1", obs.rdata, obs.lat, obs.rcyc); end
    endtask

    task automatic test_load_extend();
        logic [5:0]  ops  [4] = '{6'h20, 6'h24, 6'h21, 6'h25};
        logic [31:0] as   [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] want [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011, 32'h0000_2233};
        res_t obs, exp;
        preload(6'd4, 32'h8011_2233);
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], $urandom, obs);
            exp = model(ops[i], as[i], 32'h0);
            n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL load_ext_%0d got %s want %s", i, fmt(obs), fmt(exp)); end
            n_checks++; if (obs.rdata !== want[i]) begin n_fail++; $display("FAIL load_ext_const_%0d got=%h want=%h", i, obs.rdata, want[i]); end
        end
    endtask

    task automatic test_subword_store();
        res_t obs, exp;
        preload(6'd8, 32'hAABB_CCDD);
        run_op(6'h29, 32'h22, 32'h0000_1234, obs);
        exp = model(6'h29, 32'h22, 32'h0000_1234);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL sh_0x22 got %s want %s", fmt(obs), fmt(exp)); end
        n_checks++; if (obs.wdat !== 32'h1234_CCDD || obs.wcyc !== 4'd3 || obs.lat !== 4'd4)
            begin n_fail++; $display("FAIL sh_0x22_const got wd=%h wcyc=%0d lat=%0d want 1234CCDD 3 4", obs.wdat, obs.wcyc, obs.lat); end
        run_op(6'h28, 32'h21, 32'h0000_0077, obs);
        exp = model(6'h28, 32'h21, 32'h0000_0077);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL sb_0x21 got %s want %s", fmt(obs), fmt(exp)); end
        n_checks++; if (obs.wdat !== 32'h1234_77DD) begin n_fail++; $display("FAIL sb_0x21_const got=%h want=123477DD", obs.wdat); end
    endtask

    task automatic test_misalign();
        res_t obs, exp;
        preload(6'd1, 32'h0BAD_F00D);
        run_op(6'h23, 32'h06, 32'h0, obs);
        exp = model(6'h23, 32'h06, 32'h0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL lw_0x06 got %s want %s", fmt(obs), fmt(exp)); end
`ifdef MEM_MISALIGN_TRAP_EN
        n_checks++; if (obs.mis !== 1'b1 || obs.lat !== 4'd1 || obs.nre !== 2'd0 || obs.nwe !== 2'd0)
            begin n_fail++; $display("FAIL lw_0x06_trap got mis=%b lat=%0d re=%0d we=%0d want 1 1 0 0", obs.mis, obs.lat, obs.nre, obs.nwe); end
`else
        n_checks++; if (obs.mis !== 1'b0 || obs.rdata !== 32'h0BAD_F00D || obs.maddr !== 32'h04)
            begin n_fail++; $display("FAIL lw_0x06_align got mis=%b rd=%h ma=%h want 0 0BADF00D 4", obs.mis, obs.rdata, obs.maddr); end
`endif
        run_op(6'h29, 32'h05, 32'h0000_5A5A, obs);
        exp = model(6'h29, 32'h05, 32'h0000_5A5A);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL sh_0x05 got %s want %s", fmt(obs), fmt(exp)); end
    endtask

    task automatic test_nonmem();
        res_t obs, exp;
        run_op(6'h00, 32'h10, 32'hFFFF_FFFF, obs);
        exp = model(6'h00, 32'h10, 32'hFFFF_FFFF);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL nonmem got %s want %s", fmt(obs), fmt(exp)); end
        n_checks++; if (obs.lat !== 4'd1 || obs.rdata !== 32'h0 || obs.mis !== 1'b0 || obs.nre !== 2'd0)
            begin n_fail++; $display("FAIL nonmem_const got lat=%0d rd=%h mis=%b re=%0d want 1 0 0 0", obs.lat, obs.rdata, obs.mis, obs.nre); end
    endtask

    task automatic test_reset_midop();
        res_t obs, exp;
        int seen;
        preload(6'd12, 32'h5566_7788);
        issue(6'h28, 32'h31, 32'h0000_00AB);
        repeat (3) @(negedge CLK);
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL midop_in_wr got we=%b want=1", mem_we); end
        RST = 1'b1;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL midop_we_gated got we=%b want=0", mem_we); end
        @(negedge CLK);
        RST = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            begin n_fail++; $display("FAIL midop_idle got ready=%b resp=%b want 1 0", req_ready, resp_valid); end
        seen = 0;
        repeat (4) begin
            @(negedge CLK);
            if (resp_valid === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midop_no_resp got=%0d want=0", seen); end
        n_checks++; if (dmem[12] !== 32'h5566_7788) begin n_fail++; $display("FAIL midop_mem got=%h want=55667788", dmem[12]); end
        run_op(6'h23, 32'h30, $urandom, obs);
        exp = model(6'h23, 32'h30, 32'h0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL midop_lw got %s want %s", fmt(obs), fmt(exp)); end
    endtask

    task automatic test_back_to_back();
        res_t obs, exp;
        int rc, rdy;
        logic [31:0] v;
        v = $urandom;
        @(negedge CLK);
        req_valid = 1'b1; opcode = 6'h2B; addr = 32'h40; wdata = v;
        exp = model(6'h2B, 32'h40, v);
        @(posedge CLK);
        #1;
        opcode = 6'h23; wdata = $urandom;
        rc = -1; rdy = -1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            if (resp_valid === 1'b1 && rc < 0) rc = c;
            if (req_ready === 1'b1 && rdy < 0) rdy = c;
        end
        n_checks++; if (rc != 2 || rdy != 3) begin n_fail++; $display("FAIL b2b_timing got resp@%0d ready@%0d want 2 3", rc, rdy); end
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        observe(obs);
        exp = model(6'h23, 32'h40, 32'h0);
        n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL b2b_lw got %s want %s", fmt(obs), fmt(exp)); end
        n_checks++; if (obs.rdata !== v) begin n_fail++; $display("FAIL b2b_lw_data got=%h want=%h", obs.rdata, v); end
    endtask

    task automatic test_random();
        logic [5:0]  ops [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
        logic [5:0]  op;
        logic [31:0] a, wd;
        res_t obs, exp;
        int bad;
        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 9) < 9) ? ops[$urandom_range(0, 7)] : 6'($urandom);
            a  = $urandom_range(0, 255);
            wd = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            run_op(op, a, wd, obs);
            exp = model(op, a, wd);
            n_checks++; if (obs !== exp) begin n_fail++; $display("FAIL rand_%0d op=%h addr=%h got %s want %s", i, op, a, fmt(obs), fmt(exp)); end
        end
        bad = 0;
        for (int i = 0; i < 64; i++) if (dmem[i] !== ref_mem[i]) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mem_image got=%0d words differ want=0", bad); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
        test_load_word();
        test_load_extend();
        test_subword_store();
        test_misalign();
        test_nonmem();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
